// File: rtl/fat_level_scanner.sv
// Read-side FAT client: walks entries 0..VAR_NUM-1 one per cycle and collects
// which ones equal (or are at/above) a latched level.
module fat_level_scanner #(
    parameter int VAR_NUM     = 8,
    parameter int VAR_NUM_LOG = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VAR_NUM_LOG-1:0] cmp_level,
    input  logic                   cmp_mode,
    input  logic                   abort,
    output logic                   fat_en,
    output logic                   fat_write,
    output logic [VAR_NUM:0]       fat_address,
    input  logic [VAR_NUM_LOG-1:0] fat_out,
    output logic                   busy,
    output logic                   done,
    output logic [VAR_NUM-1:0]     match_mask,
    output logic [VAR_NUM_LOG:0]   match_count,
    output logic [VAR_NUM_LOG-1:0] first_idx,
    output logic                   any_match
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [VAR_NUM_LOG-1:0] r_idx;
    logic [VAR_NUM_LOG-1:0] r_level;
    logic                   r_mode;
    logic [VAR_NUM-1:0]     r_mask;
    logic [VAR_NUM_LOG:0]   r_count;
    logic [VAR_NUM_LOG-1:0] r_first;
    logic                   r_any;

    logic                   w_last;
    logic                   w_match;
    logic                   w_accept;
    logic [VAR_NUM-1:0]     w_idx_onehot;

    assign w_last  = (r_idx == VAR_NUM_LOG'(VAR_NUM - 1));
    assign w_match = r_mode ? (fat_out >= r_level) : (fat_out == r_level);
    // In DONE an abort wins over a simultaneous start; in IDLE abort is ignored.
    assign w_accept = start && ((r_state == IDLE) || ((r_state == DONE) && !abort));

    genvar gi;
    generate
        for (gi = 0; gi < VAR_NUM; gi++) begin : g_onehot
            assign w_idx_onehot[gi] = (r_idx == VAR_NUM_LOG'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        fat_en       = 1'b0;
        fat_write    = 1'b0;
        fat_address  = '0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = SCAN;
            end
            SCAN: begin
                busy        = 1'b1;
                fat_en      = 1'b1;
                fat_address = (VAR_NUM + 1)'(r_idx);
                if (abort)       w_state_next = IDLE;
                else if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (w_accept) w_state_next = SCAN;
                else          w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_level <= '0;
            r_mode  <= 1'b0;
            r_mask  <= '0;
            r_count <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_level <= cmp_level;
            r_mode  <= cmp_mode;
            r_mask  <= '0;
            r_count <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
        end else if (r_state == SCAN) begin
            if (abort) begin
                r_idx   <= '0;
                r_mask  <= '0;
                r_count <= '0;
                r_first <= '0;
                r_any   <= 1'b0;
            end else begin
                if (w_match) begin
                    r_mask  <= r_mask | w_idx_onehot;
                    r_count <= r_count + (VAR_NUM_LOG + 1)'(1);
                    if (!r_any) begin
                        r_first <= r_idx;
                        r_any   <= 1'b1;
                    end
                end
                if (!w_last) r_idx <= r_idx + VAR_NUM_LOG'(1);
            end
        end
    end

    assign match_mask  = r_mask;
    assign match_count = r_count;
    assign first_idx   = r_first;
    assign any_match   = r_any;

endmodule

// File: tb/tb_fat_level_scanner.sv
// Scoreboard bench for fat_level_scanner: expected results are queued at start
// and compared when done pulses.
module tb_fat_level_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] cmp_level;
    logic       cmp_mode;
    logic       abort;
    logic       fat_en;
    logic       fat_write;
    logic [8:0] fat_address;
    logic [2:0] fat_out;
    logic       busy;
    logic       done;
    logic [7:0] match_mask;
    logic [3:0] match_count;
    logic [2:0] first_idx;
    logic       any_match;

    logic [2:0] fat_mem [8];

    typedef struct {
        logic [7:0] mask;
        logic [3:0] count;
        logic [2:0] first;
        logic       any;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fat_level_scanner #(.VAR_NUM(8), .VAR_NUM_LOG(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmp_level   (cmp_level),
        .cmp_mode    (cmp_mode),
        .abort       (abort),
        .fat_en      (fat_en),
        .fat_write   (fat_write),
        .fat_address (fat_address),
        .fat_out     (fat_out),
        .busy        (busy),
        .done        (done),
        .match_mask  (match_mask),
        .match_count (match_count),
        .first_idx   (first_idx),
        .any_match   (any_match)
    );

    always #5 clk = ~clk;

    assign fat_out = (fat_address < 9'd8) ? fat_mem[fat_address[2:0]] : 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] lvl, input logic md);
        exp_t e;
        e.mask = '0; e.count = '0; e.first = '0; e.any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (md ? (fat_mem[i] >= lvl) : (fat_mem[i] == lvl)) begin
                e.mask[i] = 1'b1;
                e.count   = e.count + 4'd1;
                if (!e.any) begin
                    e.first = 3'(i);
                    e.any   = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic check_zero_results(input string tag);
        check({tag, "_mask"},  32'(match_mask),  32'h0);
        check({tag, "_count"}, 32'(match_count), 32'h0);
        check({tag, "_first"}, 32'(first_idx),   32'h0);
        check({tag, "_any"},   32'(any_match),   32'h0);
        check({tag, "_busy"},  32'(busy),        32'h0);
        check({tag, "_done"},  32'(done),        32'h0);
        check({tag, "_addr"},  32'(fat_address), 32'h0);
        check({tag, "_en"},    32'(fat_en),      32'h0);
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("scan complete: mask=%h count=%0d first=%0d any=%0d",
                         match_mask, match_count, first_idx, any_match);
                check("mask",  32'(match_mask),  32'(e.mask));
                check("count", 32'(match_count), 32'(e.count));
                check("first", 32'(first_idx),   32'(e.first));
                check("any",   32'(any_match),   32'(e.any));
            end
        end
    end

    // kind: 0 normal, 1 abort on 4th scan cycle, 2 async reset mid-scan.
    // Called at a negedge with the DUT in IDLE or DONE; returns at a negedge.
    task automatic do_scan(input logic [2:0] lvl, input logic md, input int kind,
                           input int start_pulse_at);
        start     = 1'b1;
        cmp_level = lvl;
        cmp_mode  = md;
        sb_q.push_back(model(lvl, md));
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("scan_busy", 32'(busy),        32'h1);
            check("scan_done", 32'(done),        32'h0);
            check("scan_en",   32'(fat_en),      32'h1);
            check("scan_addr", 32'(fat_address), 32'(k));
            check("scan_wr",   32'(fat_write),   32'h0);
            if (k == 0) begin
                cmp_level = ~lvl;
                cmp_mode  = ~md;
            end
            start = (k == start_pulse_at);
            if (k == 3 && kind == 1) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                void'(sb_q.pop_back());
                check_zero_results("abort");
                $display("scan aborted at idx 3");
                return;
            end
            if (k == 3 && kind == 2) begin
                #2 rst = 1'b1;
                #1 check_zero_results("async_rst");
                #1 rst = 1'b0;
                void'(sb_q.pop_back());
                $display("scan reset at idx 3");
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("end_done", 32'(done), 32'h1);
        check("end_busy", 32'(busy), 32'h0);
        check("end_en",   32'(fat_en), 32'h0);
        check("end_addr", 32'(fat_address), 32'h0);
        check("end_wr",   32'(fat_write), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmp_level = '0; cmp_mode = 1'b0; abort = 1'b0;
        for (int i = 0; i < 8; i++) fat_mem[i] = 3'd0;
        #1;
        check_zero_results("reset");
        check("reset_wr", 32'(fat_write), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_scan(3'd0, 1'b0, 0, -1);
        @(negedge clk);

        fat_mem[0] = 3'd0; fat_mem[1] = 3'd2; fat_mem[2] = 3'd5; fat_mem[3] = 3'd2;
        fat_mem[4] = 3'd7; fat_mem[5] = 3'd1; fat_mem[6] = 3'd2; fat_mem[7] = 3'd3;
        do_scan(3'd2, 1'b0, 0, -1);
        @(negedge clk);
        do_scan(3'd3, 1'b1, 0, -1);
        @(negedge clk);
        do_scan(3'd7, 1'b0, 0, -1);
        @(negedge clk);

        // abort then start pulsed during scan
        do_scan(3'd2, 1'b1, 1, -1);
        @(negedge clk);
        do_scan(3'd2, 1'b0, 0, 2);
        @(negedge clk);

        // back-to-back: start issued in the DONE cycle
        do_scan(3'd1, 1'b1, 0, -1);
        do_scan(3'd5, 1'b1, 0, -1);
        @(negedge clk);
        check("idle_after_b2b", 32'(busy), 32'h0);

        for (int i = 0; i < 8; i++) fat_mem[i] = 3'd0;
        do_scan(3'd5, 1'b0, 0, -1);
        @(negedge clk);

        fat_mem[5] = 3'd6;
        do_scan(3'd6, 1'b0, 2, -1);
        @(negedge clk);
        do_scan(3'd6, 1'b0, 0, -1);
        @(negedge clk);
        @(negedge clk);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fat_level_scanner.md
Name: fat_level_scanner

Overview:
- Read-side client of the force assign table (FAT). The BCP unit writes one level/reason code per variable into the FAT.
- This block walks FAT entries 0..VAR_NUM-1, one per cycle, and compares each entry against a requested level.
- It returns a per-variable match mask, a match count and the lowest matching index.
- Backtrack and conflict-analysis logic use it to find which variables were forced at or above a given level.

Parameters:
- VAR_NUM, 8, number of variables scanned (entries 0..VAR_NUM-1).
- VAR_NUM_LOG, 3, width of one FAT entry and of the level operand.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  scan request, sampled in IDLE/DONE.
- cmp_level  input  VAR_NUM_LOG  level to compare against, latched on accepted start.
- cmp_mode  input  1  0 = match if entry == level; 1 = match if entry >= level (unsigned). Latched on accepted start.
- abort  input  1  cancel an in-progress scan.
- fat_en  output  1  FAT enable, driven to the FAT.
- fat_write  output  1  FAT write strobe; tied 0 (read-only client).
- fat_address  output  VAR_NUM+1  FAT address; scan index, zero-extended.
- fat_out  input  VAR_NUM_LOG  FAT combinational read data for fat_address.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse on scan completion.
- match_mask  output  VAR_NUM  bit i set if entry i matched.
- match_count  output  VAR_NUM_LOG+1  number of set bits in match_mask.
- first_idx  output  VAR_NUM_LOG  lowest matching index; 0 if none.
- any_match  output  1  match_count != 0.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, idx=0, latched level/mode=0, match_mask=0, match_count=0, first_idx=0, any_match=0, busy=0, done=0. fat_en=0, fat_write=0, fat_address=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE/DONE with start=1: latch cmp_level and cmp_mode; clear mask, count, first_idx and any_match; idx<=0; go to SCAN. Otherwise hold state and results.
- DONE always leaves after one cycle: to SCAN if start=1, else to IDLE. Results are held until the next accepted start.
- SCAN, each cycle:
  - Drive fat_en=1 and fat_address=idx. fat_out is valid in the same cycle because the FAT read is combinational.
  - Evaluate the match using the latched level and mode.
  - On match: set mask[idx], increment count. If any_match was 0, load first_idx=idx and set any_match.
  - If idx==VAR_NUM-1, go to DONE; else idx<=idx+1.
- Outside SCAN: fat_en=0 and fat_address=0. fat_write is 0 in every state.
- Latency: start accepted at edge N. SCAN occupies cycles N+1..N+VAR_NUM. done=1 during cycle N+VAR_NUM+1.
- busy: 1 exactly in SCAN. done: 1 exactly in DONE.
- start during SCAN: ignored; no queuing.
- abort during SCAN: next state IDLE, no done pulse. Partial results are cleared to 0. abort in IDLE/DONE is ignored, except that abort has priority over start in DONE (go to IDLE).
- cmp_level/cmp_mode changes during SCAN: no effect (latched copies are used).
- Arithmetic: compare is unsigned on VAR_NUM_LOG bits. match_count saturates by construction at VAR_NUM, which fits in VAR_NUM_LOG+1 bits.
- FAT entry VAR_NUM is never addressed.
- rst asserted mid-scan: immediate return to reset values; no done pulse.

Test Plan:
- After reset, FAT all 0; start with level=0, mode=0 -> fat_address steps 0..7 on consecutive cycles; done at cycle 9 after start; mask=8'hFF, count=8, first_idx=0.
- FAT = {0,2,5,2,7,1,2,3} for idx 0..7; level=2, mode=0 -> mask=8'b0100_1010, count=3, first_idx=1, any_match=1.
- Same FAT; level=3, mode=1 -> mask=8'b1001_0100, count=3, first_idx=2. Then level=7, mode=0 -> mask=8'b0001_0000, count=1, first_idx=4.
- No match: FAT all 0, level=5, mode=0 -> mask=0, count=0, first_idx=0, any_match=0; done still pulses.
- abort asserted on 4th SCAN cycle -> IDLE next cycle, no done, outputs 0. start pulsed during SCAN -> ignored, the scan completes normally. start held high in DONE -> back-to-back scan, with busy rising the cycle after done.
- rst pulsed asynchronously mid-scan (between clock edges) -> all outputs 0 immediately. fat_write observed 0 throughout all tests.
